// File: rtl/digit_update_sched.sv
// MM:SS BCD time counter with one shared digit incrementer stepping one digit per cycle.
// Count and adjust requests are queued in single-entry pending flags and served from IDLE.
module digit_update_sched #(
  parameter int MIN_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       count_enable,
  input  logic       sel_minutes,
  input  logic       sel_seconds,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       busy,
  output logic       overflow,
  output logic       dropped
);

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  typedef enum logic [2:0] {IDLE, SEC1, SEC10, MIN1, MIN10} state_t;

  state_t state, state_nxt;
  logic   pend_cnt, pend_adj, adj_min, chain_cnt;
  logic   req_cnt, req_adj;
  logic   disp_cnt, disp_adj, ovf_set;

  assign req_cnt = tick_1hz & count_enable;
  assign req_adj = tick_2hz & (sel_minutes | sel_seconds);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    disp_cnt  = 1'b0;
    disp_adj  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_cnt) begin
          disp_cnt  = 1'b1;
          state_nxt = SEC1;
        end else if (pend_adj) begin
          disp_adj  = 1'b1;
          state_nxt = adj_min ? MIN1 : SEC1;
        end
      end
      SEC1:    state_nxt = (sec_ones == 4'd9) ? SEC10 : IDLE;
      // Seconds-only adjust chain stops here instead of carrying into minutes.
      SEC10:   state_nxt = (sec_tens == 4'd5 && chain_cnt) ? MIN1 : IDLE;
      MIN1:    state_nxt = (min_ones == 4'd9) ? MIN10 : IDLE;
      MIN10: begin
        state_nxt = IDLE;
        ovf_set   = chain_cnt && (min_tens == MT_MAX);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= IDLE;
      pend_cnt  <= 1'b0;
      pend_adj  <= 1'b0;
      adj_min   <= 1'b0;
      chain_cnt <= 1'b0;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      min_tens  <= 4'd0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= ovf_set;
      if (disp_cnt)
        chain_cnt <= 1'b1;
      else if (disp_adj)
        chain_cnt <= 1'b0;

      // A request landing on a flag that is being dispatched re-arms it without loss.
      pend_cnt <= (pend_cnt & ~disp_cnt) | req_cnt;
      pend_adj <= (pend_adj & ~disp_adj) | req_adj;
      if (req_adj && !(pend_adj && !disp_adj))
        adj_min <= sel_minutes;
      dropped <= (req_cnt & pend_cnt & ~disp_cnt) | (req_adj & pend_adj & ~disp_adj);

      case (state)
        SEC1:    sec_ones <= (sec_ones == 4'd9)   ? 4'd0 : sec_ones + 4'd1;
        SEC10:   sec_tens <= (sec_tens == 4'd5)   ? 4'd0 : sec_tens + 4'd1;
        MIN1:    min_ones <= (min_ones == 4'd9)   ? 4'd0 : min_ones + 4'd1;
        MIN10:   min_tens <= (min_tens == MT_MAX) ? 4'd0 : min_tens + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_update_sched.sv
// Directed bench for digit_update_sched: vector table of single requests plus
// hand-written sequences for reset, contention, priority and clear.
module tb_digit_update_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       count_enable = 1'b0;
  logic       sel_minutes = 1'b0;
  logic       sel_seconds = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       busy, overflow, dropped;

  int tests = 0;
  int fails = 0;
  int ovf_total = 0;
  int drop_total = 0;

  digit_update_sched #(.MIN_TENS_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .count_enable(count_enable), .sel_minutes(sel_minutes), .sel_seconds(sel_seconds),
    .clear(clear), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .busy(busy), .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_total <= ovf_total + 1;
    if (dropped === 1'b1) drop_total <= drop_total + 1;
  end

  // mode: 0 counted tick, 1 adjust seconds, 2 adjust minutes, 3 adjust with both
  // selects, 4 tick_1hz with count disabled, 5 tick_2hz with no select
  typedef struct {
    int mode;
    int sm, ss;
    int em, es;
    int ebusy;
    int eovf;
  } vec_t;

  vec_t vecs[13];

  function automatic int cur_time();
    return (int'(min_tens) * 10 + int'(min_ones)) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_adj(input bit minutes);
    tick_2hz    = 1'b1;
    sel_minutes = minutes;
    sel_seconds = !minutes;
    step();
    tick_2hz    = 1'b0;
    sel_minutes = 1'b0;
    sel_seconds = 1'b0;
    repeat (6) step();
  endtask

  task automatic set_time(input int m, input int s);
    count_enable = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    for (int i = 0; i < m; i++) press_adj(1'b1);
    for (int i = 0; i < s; i++) press_adj(1'b0);
  endtask

  initial begin
    int busy_n, ovf_n, got, d0, o0;

    vecs[0]  = '{0,  0,  0,  0,  1, 1, 0};
    vecs[1]  = '{0,  0,  9,  0, 10, 2, 0};
    vecs[2]  = '{0,  0, 59,  1,  0, 3, 0};
    vecs[3]  = '{0,  9, 59, 10,  0, 4, 0};
    vecs[4]  = '{0, 99, 59,  0,  0, 4, 1};
    vecs[5]  = '{1, 12, 59, 12,  0, 2, 0};
    vecs[6]  = '{1, 12, 34, 12, 35, 1, 0};
    vecs[7]  = '{2, 99, 30,  0, 30, 2, 0};
    vecs[8]  = '{2, 12, 34, 13, 34, 1, 0};
    vecs[9]  = '{2, 19,  0, 20,  0, 2, 0};
    vecs[10] = '{3, 12, 34, 13, 34, 1, 0};
    vecs[11] = '{4, 37, 42, 37, 42, 0, 0};
    vecs[12] = '{5, 37, 42, 37, 42, 0, 0};

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset from a preloaded time; a tick in the first released cycle is accepted.
    set_time(37, 42);
    check("preload_3742", cur_time(), 3742);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_enable = 1'b1;
    tick_1hz = 1'b1;
    @(negedge clk);
    check("reset_time", cur_time(), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_dropped", int'(dropped), 0);
    step();
    tick_1hz = 1'b0;
    repeat (5) step();
    check("tick_after_reset", cur_time(), 1);

    foreach (vecs[v]) begin
      set_time(vecs[v].sm, vecs[v].ss);
      count_enable = (vecs[v].mode == 0 || vecs[v].mode == 4) ? (vecs[v].mode == 0) : 1'b0;
      case (vecs[v].mode)
        0, 4: tick_1hz = 1'b1;
        1: begin tick_2hz = 1'b1; sel_seconds = 1'b1; end
        2: begin tick_2hz = 1'b1; sel_minutes = 1'b1; end
        3: begin tick_2hz = 1'b1; sel_minutes = 1'b1; sel_seconds = 1'b1; end
        default: tick_2hz = 1'b1;
      endcase
      step();
      tick_1hz = 1'b0; tick_2hz = 1'b0; sel_minutes = 1'b0; sel_seconds = 1'b0;
      busy_n = 0; ovf_n = 0; got = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (busy) busy_n++;
        if (overflow) ovf_n++;
        if (c == 2 + vecs[v].ebusy) got = cur_time();
      end
      check($sformatf("vec%0d_time", v), got, vecs[v].em * 100 + vecs[v].es);
      check($sformatf("vec%0d_busy_cycles", v), busy_n, vecs[v].ebusy);
      check($sformatf("vec%0d_overflow", v), ovf_n, vecs[v].eovf);
      step();
    end

    // Contention: two extra ticks during a full-wrap chain, one queued and one lost.
    set_time(99, 59);
    count_enable = 1'b1;
    d0 = drop_total; o0 = ovf_total;
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
    tick_1hz = 1'b1; step();
    step();
    tick_1hz = 1'b0;
    repeat (12) step();
    check("contention_time", cur_time(), 1);
    check("contention_dropped", drop_total - d0, 1);
    check("contention_overflow", ovf_total - o0, 1);

    // Priority: count and seconds-adjust together; count is served first.
    set_time(0, 0);
    count_enable = 1'b1;
    d0 = drop_total;
    tick_1hz = 1'b1; tick_2hz = 1'b1; sel_seconds = 1'b1;
    step();
    tick_1hz = 1'b0; tick_2hz = 1'b0; sel_seconds = 1'b0;
    step();
    step();
    @(negedge clk);
    check("priority_count_first", cur_time(), 1);
    repeat (4) step();
    check("priority_final", cur_time(), 2);

    // A tick in the dispatch cycle keeps the flag armed without a drop.
    tick_1hz = 1'b1; step();
    step();
    tick_1hz = 1'b0;
    repeat (8) step();
    check("redispatch_time", cur_time(), 4);
    check("redispatch_no_drop", drop_total - d0, 0);

    // Clear in the middle of a carry chain aborts it.
    set_time(9, 59);
    count_enable = 1'b1;
    o0 = ovf_total;
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
    step();
    clear = 1'b1; step();
    clear = 1'b0;
    @(negedge clk);
    check("clear_mid_time", cur_time(), 0);
    check("clear_mid_busy", int'(busy), 0);
    repeat (6) step();
    check("clear_mid_aborted", cur_time(), 0);
    check("clear_mid_overflow", ovf_total - o0, 0);

    // A request coincident with clear is silently discarded.
    d0 = drop_total;
    clear = 1'b1; tick_1hz = 1'b1; step();
    clear = 1'b0; tick_1hz = 1'b0;
    repeat (6) step();
    check("clear_req_time", cur_time(), 0);
    check("clear_req_no_drop", drop_total - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
